tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the UART transmitter, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 255: cycles data_wen may stay low waiting for tx_rdy to fall; range 1..65535.
REQ-003 Port clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  N_REQ  per-requester send request, level, held until ack.
REQ-006 Port req_data  input  8*N_REQ  byte from requester i on bits [8i+7:8i], stable while req[i] is high.
REQ-007 Port ack  output  N_REQ  one-cycle pulse: requester's byte was accepted by the transmitter.
REQ-008 Port tx_rdy  input  1  UART transmitter idle, high when it can take a byte.
REQ-009 Port data_wen  output  1  active-low write strobe to the transmitter.
REQ-010 Port data  output  8  byte to the transmitter, valid while data_wen is low.
REQ-011 Port err  output  1  one-cycle pulse on timeout abort.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 All outputs registered; FSM states IDLE, STROBE, WAIT_DONE.
REQ-014 IDLE: if tx_rdy=1 and any req bit set, select a winner, latch its byte into data, register grant index, go STROBE; otherwise stay.
REQ-015 Latency: req sampled high in IDLE with tx_rdy=1 -> data_wen low on the next rising edge.
REQ-016 STROBE: data_wen held 0; when tx_rdy sampled 0, drive data_wen 1, pulse ack[grant] for exactly one cycle, go WAIT_DONE.
REQ-017 STROBE timeout: a 16-bit counter cleared on entry increments each STROBE cycle; when it equals TIMEOUT_CYC with tx_rdy still 1, drive data_wen 1, pulse err, no ack, go IDLE; requester stays pending.
REQ-018 WAIT_DONE: data_wen 1; when tx_rdy sampled 1, advance arbitration pointer, go IDLE.
REQ-019 Arbitration is round-robin: search starts at index (last_grant+1) mod N_REQ, wraps through all N_REQ, first set req wins.
REQ-020 After timeout the pointer is not advanced; the same requester wins again if still requesting.
REQ-021 req change after grant is ignored: latched data and grant index are used to completion.
REQ-022 Simultaneous ack and new req from the same requester: new req is a new byte, eligible on the next IDLE arbitration.
REQ-023 At most one ack bit is high in any cycle; ack and err never high in the same cycle.
REQ-024 data retains its last value when data_wen is high.

Reset
REQ-025 rst high on a clock edge: state IDLE, data_wen 1, data 8'h00, ack 0, err 0, busy 0, timeout counter 0, last_grant N_REQ-1 (index 0 highest priority first).
REQ-026 rst during STROBE or WAIT_DONE aborts the transfer without ack or err; the requester re-arbitrates after reset.

Configuration
REQ-027 Macro TX_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and the pointer logic is removed; when undefined, round-robin per REQ-019.

Structure
REQ-028 Shared package tx_arb_pkg holds the state enumeration, default N_REQ and TIMEOUT_CYC constants, and the timeout counter width.
REQ-029 Winner selection lives in sub-module rr_pick (inputs req, last_grant; outputs grant index, valid), combinational, instantiated once.

Verification
REQ-030 req=3'b001, data0=8'hA4, tx_rdy=1, UART model drops tx_rdy 2 cycles after strobe -> data=8'hA4, data_wen low 2 cycles, ack=3'b001 one cycle.
REQ-031 req=3'b111 held, bytes 8'h10/8'h21/8'h32 -> transmitted order 10,21,32,10 with round-robin; with TX_ARB_FIXED_PRIO_EN order 10,10,10.
REQ-032 tx_rdy stuck at 1 after strobe, TIMEOUT_CYC=4 -> data_wen low exactly 4 cycles, err pulse, no ack, same requester re-granted.
REQ-033 tx_rdy=0 while req=3'b010 -> data_wen stays 1 until tx_rdy rises, then strobe on next edge.
REQ-034 rst asserted in WAIT_DONE -> next cycle data_wen=1, busy=0, data=8'h00, no ack/err, requester 0 highest priority afterward.
REQ-035 req[2] dropped after grant, data changed to 8'hFF -> originally latched byte sent, ack[2] still pulsed.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared FSM states and sizing constants for the UART transmit arbiter
package tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE} state_t;
  localparam int N_REQ_DEF = 3;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int TMO_CNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner selection; fixed priority when TX_ARB_FIXED_PRIO_EN is defined
module rr_pick import tx_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             valid
);
  logic [IW-1:0] idx;
`ifdef TX_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_grant;
  // lowest set index wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'(i);
      grant = req[idx] ? idx : grant;
    end
  end
`else
  // search starts one past the last grant; the nearest set bit wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      grant = req[idx] ? idx : grant;
    end
  end
`endif
  assign valid = |req;
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART transmitter among N_REQ requesters; TX_ARB_FIXED_PRIO_EN selects fixed priority
module tx_arbiter import tx_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  input  logic               tx_rdy,
  output logic               data_wen,
  output logic [7:0]         data,
  output logic               err,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);
  state_t state;
  logic [IW-1:0] grant, win, last_grant;
  logic win_v;
  logic [TMO_CNT_W-1:0] cnt, cnt_nx;
  assign cnt_nx = cnt + 1'b1;
`ifdef TX_ARB_FIXED_PRIO_EN
  assign last_grant = '0;
`endif
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(req),
    .last_grant(last_grant),
    .grant(win),
    .valid(win_v)
  );
  // transfer FSM: latch winner, strobe until the transmitter takes the byte or the wait times out
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_wen <= 1'b1;
      data <= 8'h00;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      grant <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
      last_grant <= IW'(N_REQ - 1);
`endif
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: if (tx_rdy && win_v) begin
          data <= req_data[{win, 3'b000} +: 8];
          grant <= win;
          data_wen <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= STROBE;
        end
        STROBE: if (!tx_rdy) begin
          data_wen <= 1'b1;
          ack[grant] <= 1'b1;
          state <= WAIT_DONE;
        end else if (cnt_nx == TMO_CNT_W'(TIMEOUT_CYC)) begin
          data_wen <= 1'b1;
          err <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          cnt <= cnt_nx;
        end
        WAIT_DONE: if (tx_rdy) begin
`ifndef TX_ARB_FIXED_PRIO_EN
          last_grant <= grant;
`endif
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scenario tasks plus a randomized run against a round-robin reference model
module tb_tx_arbiter;
  localparam int N = 3;
  localparam int TO = 4;
  logic clk = 0, rst = 1, tx_rdy = 1, data_wen, err, busy;
  logic [N-1:0] req = '0, ack;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] data;
  int checks = 0, errors = 0;
  int mode = 0, drop_dly = 2, busy_len = 3, lowcnt = 0, bcnt = 0;
  int curlow = 0, err_n = 0, bad_excl = 0;
  logic prev_wen = 1, fell = 0;
  logic [7:0] tx_q[$];
  int low_q[$];
  logic [N-1:0] ack_q[$];

  tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_rdy(tx_rdy), .data_wen(data_wen), .data(data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // UART model: mode 0 drops tx_rdy drop_dly cycles into a strobe and stays busy busy_len cycles; 1 stuck high; 2 held low
  always @(posedge clk) begin
    #2;
    if (mode == 2) tx_rdy = 0;
    else if (mode == 1) tx_rdy = 1;
    else if (bcnt > 0) begin
      bcnt--;
      tx_rdy = (bcnt == 0);
    end else if (!data_wen) begin
      lowcnt++;
      if (lowcnt >= drop_dly) begin
        tx_rdy = 0;
        bcnt = busy_len;
        lowcnt = 0;
      end
    end else begin
      tx_rdy = 1;
      lowcnt = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    fell = prev_wen && !data_wen;
    if (fell) tx_q.push_back(data);
    if (!data_wen) curlow++;
    else if (curlow != 0) begin
      low_q.push_back(curlow);
      curlow = 0;
    end
    if (ack != '0) ack_q.push_back(ack);
    if (err) err_n++;
    if ($countones(ack) > 1 || (ack != '0 && err)) bad_excl++;
    prev_wen = data_wen;
  endtask

  task automatic clr();
    tx_q.delete();
    low_q.delete();
    ack_q.delete();
    err_n = 0;
    curlow = 0;
    bad_excl = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    prev_wen = 1;
    curlow = 0;
  endtask

  task automatic wait_ack(input int bound);
    int n = 0;
    while (ack_q.size() == 0 && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((req != '0 || busy) && n < 200) begin
      step();
      req &= ~ack;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    req = 3'b111;
    req_data = 24'h32_21_10;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_wen, busy, ack, err, data} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state got wen=%b busy=%b ack=%b err=%b data=%h want 1 0 000 0 00", data_wen, busy, ack, err, data);
    end
    req = '0;
    rst = 0;
    prev_wen = 1;
  endtask

  task automatic test_single();
    do_reset();
    clr();
    mode = 0;
    drop_dly = 2;
    busy_len = 3;
    req_data[7:0] = 8'hA4;
    req = 3'b001;
    step();
    checks++;
    if (data_wen !== 1'b0 || data !== 8'hA4) begin
      errors++;
      $display("FAIL single_latency got wen=%b data=%h want 0 a4", data_wen, data);
    end
    wait_ack(40);
    req = '0;
    repeat (8) step();
    checks++;
    if (ack_q.size() != 1 || ack_q[0] !== 3'b001) begin
      errors++;
      $display("FAIL single_ack got %0d pulses first=%b want 1 pulse 001", ack_q.size(), ack_q.size() ? ack_q[0] : 3'b000);
    end
    checks++;
    if (low_q.size() != 1 || low_q[0] != 2) begin
      errors++;
      $display("FAIL single_strobe_len got %0d strobes len=%0d want 1 strobe len 2", low_q.size(), low_q.size() ? low_q[0] : -1);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'hA4 || err_n != 0) begin
      errors++;
      $display("FAIL single_data got n=%0d first=%h err=%0d want 1 a4 0", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, err_n);
    end
  endtask

  task automatic test_rr();
    logic [7:0] exp_b[$];
    int last = N - 1;
    int w, n = 0;
    do_reset();
    clr();
    mode = 0;
    drop_dly = 1;
    busy_len = 1;
    req_data = 24'h32_21_10;
    for (int k = 0; k < 4; k++) begin
`ifdef TX_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (last + 1) % N;
`endif
      exp_b.push_back(req_data[8*w +: 8]);
      last = w;
    end
    req = 3'b111;
    while (ack_q.size() < 4 && n < 200) begin
      step();
      n++;
    end
    req = '0;
    repeat (10) step();
    checks++;
    if (tx_q.size() != 4) begin
      errors++;
      $display("FAIL rr_count got %0d transfers want 4", tx_q.size());
    end
    for (int k = 0; k < 4 && k < tx_q.size(); k++) begin
      checks++;
      if (tx_q[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL rr_order[%0d] got %h want %h", k, tx_q[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    clr();
    mode = 1;
    req_data[15:0] = 16'h5B_A4;
    req = 3'b011;
    while (err_n == 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (err_n != 1 || low_q.size() != 1 || low_q[0] != TO) begin
      errors++;
      $display("FAIL timeout_len got err=%0d strobes=%0d len=%0d want 1 1 %0d", err_n, low_q.size(), low_q.size() ? low_q[0] : -1, TO);
    end
    checks++;
    if (ack_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_noack got %0d acks want 0", ack_q.size());
    end
    mode = 0;
    drop_dly = 1;
    busy_len = 2;
    wait_ack(40);
    req = '0;
    repeat (6) step();
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hA4 || tx_q[1] !== 8'hA4) begin
      errors++;
      $display("FAIL timeout_regrant_data got n=%0d second=%h want 2 a4", tx_q.size(), tx_q.size() > 1 ? tx_q[1] : 8'h00);
    end
    checks++;
    if (ack_q.size() != 1 || ack_q[0] !== 3'b001 || err_n != 1) begin
      errors++;
      $display("FAIL timeout_regrant_ack got n=%0d ack=%b err=%0d want 1 001 1", ack_q.size(), ack_q.size() ? ack_q[0] : 3'b000, err_n);
    end
  endtask

  task automatic test_tx_low();
    do_reset();
    clr();
    mode = 2;
    step();
    req_data[15:8] = 8'h3C;
    req = 3'b010;
    repeat (6) step();
    checks++;
    if (curlow != 0 || tx_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL txlow_hold got low=%0d strobes=%0d busy=%b want 0 0 0", curlow, tx_q.size(), busy);
    end
    mode = 0;
    drop_dly = 2;
    busy_len = 2;
    step();
    checks++;
    if (data_wen !== 1'b1) begin
      errors++;
      $display("FAIL txlow_early got wen=%b want 1", data_wen);
    end
    step();
    checks++;
    if (data_wen !== 1'b0 || data !== 8'h3C) begin
      errors++;
      $display("FAIL txlow_strobe got wen=%b data=%h want 0 3c", data_wen, data);
    end
    wait_ack(40);
    req = '0;
    checks++;
    if (ack_q.size() != 1 || ack_q[0] !== 3'b010) begin
      errors++;
      $display("FAIL txlow_ack got n=%0d ack=%b want 1 010", ack_q.size(), ack_q.size() ? ack_q[0] : 3'b000);
    end
    repeat (6) step();
  endtask

  task automatic test_reset_wait();
    do_reset();
    clr();
    mode = 0;
    drop_dly = 1;
    busy_len = 6;
    req_data = 24'hC3_22_11;
    req = 3'b001;
    wait_ack(40);
    req = '0;
    repeat (10) step();
    clr();
    req = 3'b100;
    wait_ack(40);
    rst = 1;
    req = '0;
    step();
    checks++;
    if ({data_wen, busy, ack, err, data} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstwait_state got wen=%b busy=%b ack=%b err=%b data=%h want 1 0 000 0 00", data_wen, busy, ack, err, data);
    end
    rst = 0;
    clr();
    prev_wen = 1;
    req = 3'b011;
    for (int n = 0; n < 40 && tx_q.size() == 0; n++) step();
    checks++;
    if (tx_q.size() == 0 || tx_q[0] !== 8'h11) begin
      errors++;
      $display("FAIL rstwait_prio got n=%0d first=%h want 11", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
    end
    drain();
  endtask

  task automatic test_late_change();
    do_reset();
    clr();
    mode = 0;
    drop_dly = 3;
    busy_len = 2;
    req_data[23:16] = 8'h77;
    req = 3'b100;
    step();
    req = '0;
    req_data[23:16] = 8'hFF;
    wait_ack(40);
    checks++;
    if (ack_q.size() != 1 || ack_q[0] !== 3'b100) begin
      errors++;
      $display("FAIL late_ack got n=%0d ack=%b want 1 100", ack_q.size(), ack_q.size() ? ack_q[0] : 3'b000);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h77 || data !== 8'h77) begin
      errors++;
      $display("FAIL late_data got n=%0d sent=%h hold=%h want 1 77 77", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, data);
    end
    repeat (10) step();
    checks++;
    if (tx_q.size() != 1) begin
      errors++;
      $display("FAIL late_extra got %0d transfers want 1", tx_q.size());
    end
  endtask

  task automatic test_random();
    int last = N - 1;
    int cur = -1;
    int w, n_tx = 0;
    do_reset();
    clr();
    mode = 0;
    drop_dly = $urandom_range(1, 3);
    busy_len = $urandom_range(1, 4);
    for (int c = 0; c < 800; c++) begin
      step();
      if (fell) begin
        w = -1;
`ifdef TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N && w < 0; i++) if (req[i]) w = i;
`else
        for (int k = 1; k <= N && w < 0; k++) if (req[(last + k) % N]) w = (last + k) % N;
`endif
        checks++;
        if (w < 0 || data !== req_data[8*(w < 0 ? 0 : w) +: 8]) begin
          errors++;
          $display("FAIL rand_pick cyc %0d got %h want requester %0d byte %h", c, data, w, req_data[8*(w < 0 ? 0 : w) +: 8]);
        end
        cur = w;
        n_tx++;
      end
      if (ack != '0) begin
        checks++;
        if (cur < 0 || ack !== (N'(1) << cur)) begin
          errors++;
          $display("FAIL rand_ack cyc %0d got %b want requester %0d", c, ack, cur);
        end
        last = cur < 0 ? last : cur;
        for (int i = 0; i < N; i++) begin
          if (ack[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else req_data[8*i +: 8] = 8'($urandom);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    drain();
    checks++;
    if (n_tx < 20 || err_n != 0 || bad_excl != 0) begin
      errors++;
      $display("FAIL rand_summary got tx=%0d err=%0d excl_viol=%0d want >=20 0 0", n_tx, err_n, bad_excl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_tx_low();
    test_reset_wait();
    test_late_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
